// File: rtl/ysyx_220053_ifid_buf.sv
// ============================================================================
// Module   : ysyx_220053_ifid_buf
// Purpose  : Two-entry skid buffer carrying {pc, instr} pairs from IFU to IDU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_220053_ifid_buf #(
    parameter int          PC_W      = 64,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PC_W-1:0]      r_head_pc;
    logic [INSTR_W-1:0]   r_head_instr;
    logic [PC_W-1:0]      r_tail_pc;
    logic [INSTR_W-1:0]   r_tail_instr;

    logic w_fire_in;
    logic w_fire_out;
    logic w_head_from_in;
    logic w_head_from_tail;
    logic w_tail_from_in;

    // Ready looks only at registered state; rst gating keeps it low during reset.
    assign in_ready   = rst && (r_state != S_TWO);
    assign out_valid  = (r_state == S_ONE) || (r_state == S_TWO);
    assign w_fire_in  = in_valid && in_ready && !flush;
    assign w_fire_out = out_valid && out_ready;

    assign out_pc    = out_valid ? r_head_pc    : '0;
    assign out_instr = out_valid ? r_head_instr : INSTR_W'(NOP_INSTR);

    always_comb begin
        case (r_state)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_in   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_fire_in) begin
                    w_state_nxt    = S_ONE;
                    w_head_from_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_fire_in && w_fire_out) begin
                    w_head_from_in = 1'b1;
                end else if (w_fire_in) begin
                    w_state_nxt    = S_TWO;
                    w_tail_from_in = 1'b1;
                end else if (w_fire_out) begin
                    w_state_nxt    = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_fire_out) begin
                    w_state_nxt      = S_ONE;
                    w_head_from_tail = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Data loads are harmless under flush since outputs are masked when empty.
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_pc    <= '0;
            r_head_instr <= INSTR_W'(NOP_INSTR);
            r_tail_pc    <= '0;
            r_tail_instr <= INSTR_W'(NOP_INSTR);
        end else begin
            if (w_head_from_in) begin
                r_head_pc    <= in_pc;
                r_head_instr <= in_instr;
            end else if (w_head_from_tail) begin
                r_head_pc    <= r_tail_pc;
                r_head_instr <= r_tail_instr;
            end
            if (w_tail_from_in) begin
                r_tail_pc    <= in_pc;
                r_tail_instr <= in_instr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_220053_ifid_buf.sv
// ============================================================================
// Module   : tb_ysyx_220053_ifid_buf
// Purpose  : Directed bench with a FIFO scoreboard for the IF/ID skid buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_220053_ifid_buf;

    localparam logic [31:0] C_NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // Scoreboard: pairs accepted but not yet consumed, oldest first.
    logic [95:0] sb_q[$];

    ysyx_220053_ifid_buf #(
        .PC_W      (64),
        .INSTR_W   (32),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the scoreboard; called with rst high.
    task automatic check_outputs(input string tag);
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        e_pc    = (sb_q.size() > 0) ? sb_q[0][95:32] : 64'h0;
        e_instr = (sb_q.size() > 0) ? sb_q[0][31:0]  : C_NOP;
        chk({tag, ".in_ready"},  {63'h0, in_ready},  {63'h0, (sb_q.size() < 2)});
        chk({tag, ".out_valid"}, {63'h0, out_valid}, {63'h0, (sb_q.size() > 0)});
        chk({tag, ".occupancy"}, {62'h0, occupancy}, 64'(sb_q.size()));
        chk({tag, ".out_pc"},    out_pc,             e_pc);
        chk({tag, ".out_instr"}, {32'h0, out_instr}, {32'h0, e_instr});
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input string tag, input logic v, input logic [63:0] pc,
                         input logic [31:0] ins, input logic ordy, input logic fl);
        logic fi;
        logic fo;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs(tag);
        fi = v && (sb_q.size() < 2) && !fl;
        fo = ordy && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (fo) void'(sb_q.pop_front());
        if (fl) sb_q.delete();
        else if (fi) sb_q.push_back({pc, ins});
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'hDEAD_BEEF_0000_0000;
        in_instr  = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        flush     = 1'b0;

        // Reset held for three edges with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst.out_valid", {63'h0, out_valid}, 64'h0);
            chk("rst.occupancy", {62'h0, occupancy}, 64'h0);
            chk("rst.out_instr", {32'h0, out_instr}, {32'h0, C_NOP});
            chk("rst.out_pc",    out_pc,             64'h0);
            chk("rst.in_ready",  {63'h0, in_ready},  64'h0);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.in_ready", {63'h0, in_ready}, 64'h1);

        // Streaming at full rate.
        cycle("stream0", 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b1, 1'b0);
        cycle("stream1", 1'b1, 64'h8000_0004, 32'h0020_0113, 1'b1, 1'b0);
        cycle("stream2", 1'b1, 64'h8000_0008, 32'h0030_8193, 1'b1, 1'b0);
        cycle("stream3", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);
        cycle("stream4", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);

        // Stall fills both entries; third pair is refused until space frees.
        cycle("stall0", 1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
        cycle("stall1", 1'b1, 64'h8000_0004, 32'h0020_0113, 1'b0, 1'b0);
        cycle("stall2", 1'b1, 64'h8000_0008, 32'h0030_8193, 1'b0, 1'b0);
        cycle("drain0", 1'b1, 64'h8000_0008, 32'h0030_8193, 1'b1, 1'b0);
        cycle("drain1", 1'b1, 64'h8000_0008, 32'h0030_8193, 1'b1, 1'b0);
        cycle("drain2", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);
        cycle("drain3", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);

        // Flush with a full buffer drops held and incoming pairs.
        cycle("fl_fill0", 1'b1, 64'h8000_0020, 32'h0000_0001, 1'b0, 1'b0);
        cycle("fl_fill1", 1'b1, 64'h8000_0024, 32'h0000_0002, 1'b0, 1'b0);
        cycle("fl_full",  1'b1, 64'h8000_0100, 32'h0000_0100, 1'b0, 1'b1);
        cycle("fl_after", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);

        // Flush while the head is being consumed: head delivered, input dropped.
        cycle("fl1_fill", 1'b1, 64'h8000_0030, 32'h0000_0003, 1'b0, 1'b0);
        cycle("fl1_cons", 1'b1, 64'h8000_0034, 32'h0000_0004, 1'b1, 1'b1);
        cycle("fl1_after", 1'b1, 64'h8000_0038, 32'h0000_0005, 1'b0, 1'b0);
        cycle("fl1_drain", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);

        // Simultaneous accept and consume in the single-entry state.
        cycle("sim_fill", 1'b1, 64'h8000_0010, 32'h0000_0010, 1'b0, 1'b0);
        cycle("sim_both", 1'b1, 64'h8000_0014, 32'h0000_0014, 1'b1, 1'b0);
        cycle("sim_hold", 1'b0, 64'h0,         32'h0,         1'b0, 1'b0);
        cycle("sim_drain", 1'b0, 64'h0,        32'h0,         1'b1, 1'b0);

        // Asynchronous reset between edges with two entries held.
        cycle("ar_fill0", 1'b1, 64'h8000_0040, 32'h0000_0040, 1'b0, 1'b0);
        cycle("ar_fill1", 1'b1, 64'h8000_0044, 32'h0000_0044, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("ar_pre.occupancy", {62'h0, occupancy}, 64'h2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar.out_valid", {63'h0, out_valid}, 64'h0);
        chk("ar.occupancy", {62'h0, occupancy}, 64'h0);
        chk("ar.out_instr", {32'h0, out_instr}, {32'h0, C_NOP});
        sb_q.delete();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_post0", 1'b1, 64'h8000_0050, 32'h0000_0050, 1'b1, 1'b0);
        cycle("ar_post1", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);
        cycle("ar_post2", 1'b0, 64'h0,         32'h0,         1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
